// File: rtl/i2c_seq_pkg.sv
// rtl/i2c_seq_pkg.sv - register map, command bytes, status codes and FSM states for the I2C sequencer
package i2c_seq_pkg;

  // I2C master core register addresses (TXR/RXR and CR/SR share an address)
  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  // Command register bit positions
  localparam int CR_STA = 7;
  localparam int CR_STO = 6;
  localparam int CR_RD  = 5;
  localparam int CR_WR  = 4;
  localparam int CR_ACK = 3;

  // Status register bit positions
  localparam int SR_RXACK = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  // Core enable written to CTR during init
  localparam logic [7:0] CTR_EN = 8'h80;

  // Command bytes built from the bit positions above
  localparam logic [7:0] CMD_STA_WR      = 8'((1 << CR_STA) | (1 << CR_WR));                 // 0x90
  localparam logic [7:0] CMD_WR          = 8'(1 << CR_WR);                                   // 0x10
  localparam logic [7:0] CMD_WR_STO      = 8'((1 << CR_STO) | (1 << CR_WR));                 // 0x50
  localparam logic [7:0] CMD_RD_NACK_STO = 8'((1 << CR_STO) | (1 << CR_RD) | (1 << CR_ACK)); // 0x68
  localparam logic [7:0] CMD_STO         = 8'(1 << CR_STO);                                  // 0x40

  // Response status codes
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NACK    = 2'b01;
  localparam logic [1:0] ST_AL      = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [3:0] {
    INIT_PRL, INIT_PRH, INIT_CTR, IDLE, WR_TXR, WR_CR,
    POLL_SR, STOP_CR, STOP_POLL, RD_RXR, RESP
  } seq_state_t;

  // Byte loaded into TXR for a given byte phase (phase 3 has no TXR write)
  function automatic logic [7:0] txr_byte(input logic [1:0] phase, input logic rnw,
                                          input logic [6:0] dev, input logic [7:0] reg_idx,
                                          input logic [7:0] wdata);
    case (phase)
      2'd0:    return {dev, 1'b0};
      2'd1:    return reg_idx;
      default: return rnw ? {dev, 1'b1} : wdata;
    endcase
  endfunction

  // Command written to CR for a given byte phase
  function automatic logic [7:0] cr_cmd(input logic [1:0] phase, input logic rnw);
    case (phase)
      2'd0:    return CMD_STA_WR;
      2'd1:    return CMD_WR;
      2'd2:    return rnw ? CMD_STA_WR : CMD_WR_STO;
      default: return CMD_RD_NACK_STO;
    endcase
  endfunction

endpackage

// File: rtl/i2c_seq_wb_port.sv
// rtl/i2c_seq_wb_port.sv - single outstanding Wishbone access towards the I2C master core
module i2c_seq_wb_port (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] addr,
  input  logic [7:0] data,
  input  logic       we,
  output logic       done,
  output logic [7:0] rdata,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i
);

  // Launch on start, hold the bus fields until ack, then drop stb and pulse done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 3'd0;
      wb_dat_o <= 8'h00;
      done     <= 1'b0;
      rdata    <= 8'h00;
    end else begin
      done <= 1'b0;
      if (wb_stb_o) begin
        if (wb_ack_i) begin
          wb_stb_o <= 1'b0;
          done     <= 1'b1;
          rdata    <= wb_dat_i;
        end
      end else if (start) begin
        wb_stb_o <= 1'b1;
        wb_adr_o <= addr;
        wb_dat_o <= data;
        wb_we_o  <= we;
      end
    end
  end

endmodule

// File: rtl/i2c_reg_sequencer.sv
// rtl/i2c_reg_sequencer.sv - I2C register read/write sequencer; optional poll timeout via I2C_SEQ_TIMEOUT_EN
module i2c_reg_sequencer
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE    = 16'd119,
  parameter logic [23:0] TIMEOUT_CYC = 24'd600000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  input  logic       wb_ack_i
);

  seq_state_t state;
  logic [1:0] phase;
  logic       acc_issued, acc_start, acc_done;
  logic       bus_state, acc_we;
  logic [2:0] acc_adr;
  logic [7:0] acc_dat, acc_rdata;
  logic       rnw_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q;
  logic       timed_out;

  i2c_seq_wb_port u_wb_port (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n_i),
    .start    (acc_start),
    .addr     (acc_adr),
    .data     (acc_dat),
    .we       (acc_we),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_ack_i (wb_ack_i)
  );

  // Bus access each state performs; stays stable for the whole state
  always_comb begin
    bus_state = 1'b1;
    acc_adr   = 3'd0;
    acc_dat   = 8'h00;
    acc_we    = 1'b0;
    case (state)
      INIT_PRL:  begin acc_adr = ADR_PRERLO; acc_dat = PRESCALE[7:0];  acc_we = 1'b1; end
      INIT_PRH:  begin acc_adr = ADR_PRERHI; acc_dat = PRESCALE[15:8]; acc_we = 1'b1; end
      INIT_CTR:  begin acc_adr = ADR_CTR;    acc_dat = CTR_EN;         acc_we = 1'b1; end
      WR_TXR:    begin acc_adr = ADR_TXR; acc_dat = txr_byte(phase, rnw_q, dev_q, reg_q, wdata_q); acc_we = 1'b1; end
      WR_CR:     begin acc_adr = ADR_CR;  acc_dat = cr_cmd(phase, rnw_q); acc_we = 1'b1; end
      STOP_CR:   begin acc_adr = ADR_CR;  acc_dat = CMD_STO;              acc_we = 1'b1; end
      POLL_SR:   acc_adr = ADR_SR;
      STOP_POLL: acc_adr = ADR_SR;
      RD_RXR:    acc_adr = ADR_RXR;
      default:   bus_state = 1'b0;
    endcase
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [23:0] poll_cnt;

  // Count cycles spent polling; cleared whenever the FSM leaves the poll states
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i || !(state == POLL_SR || state == STOP_POLL)) poll_cnt <= 24'd0;
    else if (poll_cnt != 24'hFF_FFFF) poll_cnt <= poll_cnt + 24'd1;
  end

  assign timed_out = (state == POLL_SR || state == STOP_POLL) && (poll_cnt >= TIMEOUT_CYC);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timed_out = 1'b0;
`endif

  // Sequencer FSM: init, accept request, walk the byte phases, recover from errors, respond
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state      <= INIT_PRL;
      phase      <= 2'd0;
      acc_issued <= 1'b0;
      acc_start  <= 1'b0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
      rsp_status <= ST_OK;
      rnw_q      <= 1'b0;
      dev_q      <= 7'd0;
      reg_q      <= 8'h00;
      wdata_q    <= 8'h00;
    end else begin
      acc_start <= 1'b0;
      if (bus_state && !acc_issued) begin
        acc_start  <= 1'b1;
        acc_issued <= 1'b1;
      end
      if (acc_done) acc_issued <= 1'b0;

      case (state)
        INIT_PRL: if (acc_done) state <= INIT_PRH;
        INIT_PRH: if (acc_done) state <= INIT_CTR;
        INIT_CTR: if (acc_done) begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        IDLE: if (req_valid && req_ready) begin
          rnw_q     <= req_rnw;
          dev_q     <= req_dev;
          reg_q     <= req_reg;
          wdata_q   <= req_wdata;
          phase     <= 2'd0;
          req_ready <= 1'b0;
          state     <= WR_TXR;
        end
        WR_TXR: if (acc_done) state <= WR_CR;
        WR_CR:  if (acc_done) state <= POLL_SR;
        POLL_SR: if (acc_done) begin
          if (acc_rdata[SR_AL]) begin
            rsp_status <= ST_AL;
            state      <= STOP_POLL;
          end else if (!acc_rdata[SR_TIP]) begin
            // RxACK after the read byte is the master's own NACK, not a device error
            if (phase != 2'd3 && acc_rdata[SR_RXACK]) begin
              rsp_status <= ST_NACK;
              state      <= STOP_CR;
            end else if (phase == 2'd3) begin
              state <= RD_RXR;
            end else if (phase == 2'd2 && !rnw_q) begin
              rsp_status <= ST_OK;
              rsp_rdata  <= 8'h00;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              phase <= phase + 2'd1;
              state <= (phase == 2'd2) ? WR_CR : WR_TXR;
            end
          end
        end
        STOP_CR: if (acc_done) state <= STOP_POLL;
        STOP_POLL: if (acc_done && !acc_rdata[SR_BUSY]) begin
          rsp_rdata <= 8'h00;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RD_RXR: if (acc_done) begin
          rsp_rdata  <= acc_rdata;
          rsp_status <= ST_OK;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= INIT_PRL;
      endcase

      // Poll limit reached: abandon without STO and report timeout
      if (acc_done && timed_out) begin
        rsp_status <= ST_TIMEOUT;
        rsp_rdata  <= 8'h00;
        rsp_valid  <= 1'b1;
        state      <= RESP;
      end
    end
  end

endmodule
